// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register: load-enabled, async active-low reset to RESET_PC.
// One-cycle latency from d to q; no backpressure (load is the only control).
module pc_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch front end: one outstanding I-cache read, 2-cycle best-case IC_Req->Valid_D.
// Decode stall holds the slot; a second word parks in the skid buffer and blocks new requests.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PCSrc,
  input  logic [XLEN-1:0]  PCTarget,
  input  logic             Stall_D,
  output logic             IC_Req,
  output logic [XLEN-1:0]  IC_Addr,
  input  logic             IC_Ready,
  input  logic             IC_RspValid,
  input  logic [XLEN-1:0]  IC_RspData,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  PCNext,
  output logic [XLEN-1:0]  Instr_D,
  output logic [XLEN-1:0]  PC_D,
  output logic             Valid_D,
  output logic [CNT_W-1:0] MissCount
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] instr_q, pcd_q, skid_instr, skid_pc;
  logic            valid_q, kill, first_wait;
  logic [CNT_W-1:0] miss_cnt;

  logic            redirect, accept, consume, rsp_live;
  logic            deliver, to_skid, unload, advance, pc_load;
  logic [XLEN-1:0] pc_plus4, pc_target;

  assign redirect  = PCSrc & (state != IDLE);
  // A killed fetch is still in flight, so no new request until its response drains.
  assign IC_Req    = (state == REQ) & ~PCSrc & ~kill;
  assign IC_Addr   = PC;
  assign accept    = IC_Req & IC_Ready;
  assign consume   = valid_q & ~Stall_D;
  assign rsp_live  = (state == WAIT) & IC_RspValid & ~kill & ~redirect;
  assign deliver   = rsp_live & (~valid_q | ~Stall_D);
  assign to_skid   = rsp_live & valid_q & Stall_D;
  assign unload    = (state == HOLD) & ~redirect & ~Stall_D;
  assign advance   = rsp_live;

  assign pc_plus4  = PC + XLEN'(4);
  assign pc_target = PCTarget & ~XLEN'(3);
  assign PCNext    = redirect ? pc_target : (advance ? pc_plus4 : PC);
  assign pc_load   = redirect | advance;

  pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (CLK),
    .rst_n (RST),
    .load  (pc_load),
    .d     (PCNext),
    .q     (PC)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (accept) state_nxt = WAIT;
      WAIT: begin
        if (IC_RspValid) begin
          if (kill || !valid_q || !Stall_D) state_nxt = REQ;
          else                              state_nxt = HOLD;
        end
      end
      HOLD: if (!Stall_D) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
    if (redirect) state_nxt = REQ;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      kill       <= 1'b0;
      first_wait <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      first_wait <= accept;
      if (redirect) begin
        kill <= ((state == WAIT) | kill) & ~IC_RspValid;
      end else if (kill && IC_RspValid) begin
        kill <= 1'b0;
      end
      if ((state == WAIT) && first_wait && !IC_RspValid && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q    <= 1'b0;
      instr_q    <= XLEN'(NOP_INSTR);
      pcd_q      <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      if (redirect) begin
        valid_q <= 1'b0;
      end else if (deliver) begin
        valid_q <= 1'b1;
        instr_q <= IC_RspData;
        pcd_q   <= PC;
      end else if (unload) begin
        valid_q <= 1'b1;
        instr_q <= skid_instr;
        pcd_q   <= skid_pc;
      end else if (consume) begin
        valid_q <= 1'b0;
      end
      if (redirect) begin
        skid_instr <= '0;
        skid_pc    <= '0;
      end else if (to_skid) begin
        skid_instr <= IC_RspData;
        skid_pc    <= PC;
      end
    end
  end

  assign Instr_D   = instr_q;
  assign PC_D      = pcd_q;
  assign Valid_D   = valid_q;
  assign MissCount = miss_cnt;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit against a queue-based transaction model.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        PCSrc, Stall_D, IC_Ready, IC_RspValid;
  logic [31:0] PCTarget, IC_RspData;
  logic        IC_Req, Valid_D;
  logic [31:0] IC_Addr, PC, PCNext, Instr_D, PC_D;
  logic [15:0] MissCount;
  logic        w_IC_Req, w_Valid_D;
  logic [31:0] w_IC_Addr, w_PC, w_PCNext, w_Instr_D, w_PC_D;
  logic [15:0] w_MissCount;

  always #5 CLK = ~CLK;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall_D(Stall_D),
    .IC_Req(IC_Req), .IC_Addr(IC_Addr), .IC_Ready(IC_Ready),
    .IC_RspValid(IC_RspValid), .IC_RspData(IC_RspData),
    .PC(PC), .PCNext(PCNext), .Instr_D(Instr_D), .PC_D(PC_D),
    .Valid_D(Valid_D), .MissCount(MissCount)
  );

  // Same stimulus, different reset PC: control must track, PC stays offset until a redirect.
  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut_w (
    .CLK(CLK), .RST(RST), .PCSrc(PCSrc), .PCTarget(PCTarget), .Stall_D(Stall_D),
    .IC_Req(w_IC_Req), .IC_Addr(w_IC_Addr), .IC_Ready(IC_Ready),
    .IC_RspValid(IC_RspValid), .IC_RspData(IC_RspData),
    .PC(w_PC), .PCNext(w_PCNext), .Instr_D(w_Instr_D), .PC_D(w_PC_D),
    .Valid_D(w_Valid_D), .MissCount(w_MissCount)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_pc, m_off;
  bit          m_idle, m_out, m_kill, exp_req;
  int          m_age, m_lat, late;
  logic [15:0] m_miss;
  ent_t        m_q[$];
  int          p_rdy, lat_lo, lat_hi, p_stall, p_redir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0;
    m_off  = 32'hFFFF_FFFC;
    m_idle = 1'b1;
    m_out  = 1'b0;
    m_kill = 1'b0;
    m_age  = 0;
    m_lat  = 1;
    m_miss = 16'h0;
    m_q.delete();
  endtask

  task automatic check_regs();
    chk("pc", PC, m_pc);
    chk("pc_wrap_inst", w_PC, m_pc + m_off);
    chk("valid_d", 32'(Valid_D), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("instr_d", Instr_D, m_q[0].instr);
      chk("pc_d", PC_D, m_q[0].pc);
    end
    chk("miss_count", 32'(MissCount), 32'(m_miss));
  endtask

  // Drive one cycle of stimulus, check combinational outputs, advance the model across the edge.
  task automatic cycle();
    bit rspv;
    PCSrc = ($urandom_range(99) < p_redir);
    case ($urandom_range(2))
      0:       PCTarget = 32'h0000_0103;
      1:       PCTarget = 32'hFFFF_FFF8 | 32'($urandom_range(7));
      default: PCTarget = $urandom;
    endcase
    Stall_D     = ($urandom_range(99) < p_stall);
    IC_Ready    = ($urandom_range(99) < p_rdy);
    IC_RspValid = (m_out && (m_age == m_lat - 1)) || (late > 0);
    if (late > 0) late--;
    IC_RspData  = $urandom;
    #1;
    exp_req = !m_idle && !m_out && (m_q.size() < 2) && !PCSrc;
    chk("ic_req", 32'(IC_Req), 32'(exp_req));
    chk("ic_req_wrap_inst", 32'(w_IC_Req), 32'(exp_req));
    if (exp_req) chk("ic_addr", IC_Addr, m_pc);

    if (m_idle) begin
      m_idle = 1'b0;
    end else begin
      rspv = m_out && IC_RspValid;
      if (m_out && (m_age == 0) && !IC_RspValid && (m_miss != 16'hFFFF)) m_miss++;
      if (PCSrc) begin
        m_pc  = PCTarget & 32'hFFFF_FFFC;
        m_off = 32'h0;
        m_q.delete();
        if (m_out && !rspv) begin
          m_kill = 1'b1;
          m_age++;
        end else begin
          m_out  = 1'b0;
          m_kill = 1'b0;
        end
      end else begin
        if ((m_q.size() > 0) && !Stall_D) void'(m_q.pop_front());
        if (rspv) begin
          if (m_kill) m_kill = 1'b0;
          else begin
            m_q.push_back('{instr: IC_RspData, pc: m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_out = 1'b0;
        end else if (m_out) begin
          m_age++;
        end else if (exp_req && IC_Ready) begin
          m_out = 1'b1;
          m_age = 0;
          m_lat = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
    chk("pc_next", PCNext, m_pc);
    @(negedge CLK);
    check_regs();
  endtask

  task automatic run_phase(input int n, input int rdy, input int lo, input int hi,
                           input int stall, input int redir);
    p_rdy = rdy; lat_lo = lo; lat_hi = hi; p_stall = stall; p_redir = redir;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    PCSrc = 1'b0; Stall_D = 1'b0; IC_Ready = 1'b0; IC_RspValid = 1'b0;
    model_reset();
    #1;
    chk("rst_pc", PC, 32'h0);
    chk("rst_pc_wrap_inst", w_PC, 32'hFFFF_FFFC);
    chk("rst_valid_d", 32'(Valid_D), 32'h0);
    chk("rst_instr_d", Instr_D, 32'h0000_0013);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_ic_req", 32'(IC_Req), 32'h0);
    chk("rst_miss", 32'(MissCount), 32'h0);
    repeat (2) @(negedge CLK);
    RST  = 1'b1;
    late = 2;
  endtask

  initial begin
    RST = 1'b0; PCSrc = 1'b0; PCTarget = 32'h0; Stall_D = 1'b0;
    IC_Ready = 1'b0; IC_RspValid = 1'b0; IC_RspData = 32'h0; late = 0;
    model_reset();
    @(negedge CLK);
    do_reset();
    late = 0;

    run_phase(20, 100, 1, 1, 0, 0);    // hit stream
    run_phase(24, 100, 5, 5, 0, 0);    // long misses
    run_phase(40, 100, 1, 2, 85, 0);   // decode stalls
    run_phase(60, 80, 1, 3, 20, 15);   // redirects

    // Reset while a fetch is outstanding; the stale response shows up afterwards.
    p_redir = 0; lat_lo = 5; lat_hi = 5; p_rdy = 100; p_stall = 0;
    begin
      int budget = 50;
      while (!m_out && budget > 0) begin
        cycle();
        budget--;
      end
      chk("outstanding_before_reset", 32'(m_out), 32'h1);
    end
    cycle();
    do_reset();

    run_phase(3000, 70, 1, 6, 40, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
